// File: rtl/pwm_gen_pkg.sv
// Shared helpers for the PWM generator slice.
package pwm_gen_pkg;

    function automatic int unsigned clamp_duty(input int unsigned value, input int unsigned limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/pwm_gen_edge_rise.sv
// Rising-edge detector for a level signal already synchronous to clk_in.
// The history flop resets high so a level that is already high at release is not an edge.
module edge_rise (
    input  logic clk_in,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic tick_d;

    always_ff @(posedge clk_in) begin
        if (reset) tick_d <= 1'b1;
        else       tick_d <= d;
    end

    assign rise = d & ~tick_d;

endmodule

// File: rtl/pwm_gen.sv
// PWM generator stepped by rising edges of the scaler output, with a
// valid/ready double-buffered duty that only switches at period boundaries.
module pwm_gen
    import pwm_gen_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned PERIOD = 255
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_start
);

    localparam logic [WIDTH-1:0] LAST_STEP = WIDTH'(PERIOD - 1);

    logic             step;
    logic             wrap;
    logic             accept;
    logic             load;
    logic             shadow_full;
    logic             shadow_full_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] duty_active;

    edge_rise u_tick_edge (
        .clk_in (clk_in),
        .reset  (reset),
        .d      (tick_in),
        .rise   (step)
    );

    // While disabled there is no period to protect, so a full shadow loads at once.
    always_comb begin
        wrap            = step & (cnt == LAST_STEP);
        accept          = duty_valid & duty_ready;
        load            = shadow_full & (enable ? wrap : 1'b1);
        shadow_full_nxt = accept | (shadow_full & ~load);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt          <= '0;
            shadow       <= '0;
            shadow_full  <= 1'b0;
            duty_active  <= '0;
            duty_ready   <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            if (!enable)   cnt <= '0;
            else if (step) cnt <= wrap ? '0 : cnt + 1'b1;

            if (accept) shadow <= WIDTH'(clamp_duty(32'(duty_in), PERIOD));
            if (load)   duty_active <= shadow;

            shadow_full  <= shadow_full_nxt;
            duty_ready   <= ~shadow_full_nxt;
            pwm_out      <= enable & (cnt < duty_active);
            period_start <= enable & wrap;
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: directed scenarios plus randomized traffic, every cycle
// compared against a step-level behavioural model of the PWM.
module tb_pwm_gen;

    localparam int W = 8;
    localparam int P = 4;
    localparam int N = 10;

    logic         clk_in = 1'b0;
    logic         reset = 1'b1;
    logic         tick_in = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] duty_in = '0;
    logic         duty_valid = 1'b0;
    logic         duty_ready;
    logic         pwm_out;
    logic         period_start;

    pwm_gen #(.WIDTH(W), .PERIOD(P)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .tick_in      (tick_in),
        .enable       (enable),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk_in = ~clk_in;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    // Reference model: position within the period, active duty, pending duty queue.
    int m_pos = 0;
    int m_duty = 0;
    int m_pending[$];
    bit m_prev_tick = 1'b1;
    bit m_pwm = 1'b0;
    bit m_start = 1'b0;
    bit m_ready = 1'b0;

    int tick_mode = 0;
    int phase = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_edge();
        bit stepped, wrapped, accepted;
        if (reset) begin
            m_pos = 0;
            m_duty = 0;
            m_pending.delete();
            m_prev_tick = 1'b1;
            m_pwm = 1'b0;
            m_start = 1'b0;
            m_ready = 1'b0;
        end else begin
            stepped     = tick_in && !m_prev_tick;
            m_prev_tick = tick_in;
            wrapped     = stepped && (m_pos == P - 1);
            accepted    = duty_valid && m_ready;
            m_pwm       = enable && (m_pos < m_duty);
            m_start     = enable && wrapped;
            if (m_pending.size() > 0 && (!enable || wrapped))
                m_duty = m_pending.pop_front();
            if (accepted)
                m_pending.push_back((int'(duty_in) > P) ? P : int'(duty_in));
            if (!enable)      m_pos = 0;
            else if (stepped) m_pos = (m_pos + 1) % P;
            m_ready = (m_pending.size() == 0);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
        model_edge();
        check("pwm_out", pwm_out, m_pwm);
        check("period_start", period_start, m_start);
        check("duty_ready", duty_ready, m_ready);
        phase = (phase + 1) % N;
        if (tick_mode == 0) tick_in = (phase >= N / 2);
        else                tick_in = 1'($urandom_range(0, 1));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic write_duty(input int value);
        bit got;
        bit was_ready;
        got = 1'b0;
        duty_in = W'(value);
        duty_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            was_ready = duty_ready;
            cyc();
            if (was_ready) got = 1'b1;
        end
        duty_valid = 1'b0;
        n_total++;
        assert (got === 1'b1) n_pass++;
        else $error("FAIL handshake_timeout: observed %b expected %b", got, 1'b1);
    endtask

    task automatic wait_pwm_high();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (pwm_out === 1'b1) seen = 1'b1;
            else cyc();
        end
        n_total++;
        assert (seen === 1'b1) n_pass++;
        else $error("FAIL wait_pwm_high: observed %b expected %b", seen, 1'b1);
    endtask

    initial begin
        // Reset state
        run(3);
        reset = 1'b0;
        run(2);

        // Duty 2 running at the scaler rate
        write_duty(2);
        enable = 1'b1;
        run(120);

        // Duty 0, then full duty
        write_duty(0);
        run(100);
        write_duty(4);
        run(100);

        // Change mid-period; valid held high must not be re-accepted while shadow full
        write_duty(1);
        run(55);
        write_duty(3);
        duty_in = W'(2);
        duty_valid = 1'b1;
        run(30);
        duty_valid = 1'b0;
        run(80);

        // Over-range request clamps to full duty
        write_duty(9);
        run(100);

        // Reset while output high with a pending shadow
        write_duty(3);
        run(45);
        wait_pwm_high();
        write_duty(1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        run(60);
        write_duty(3);
        run(60);

        // Disable mid-period, write while disabled, re-enable
        run(17);
        enable = 1'b0;
        run(5);
        write_duty(2);
        run(20);
        enable = 1'b1;
        run(100);

        // Randomized traffic with irregular tick levels
        tick_mode = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            duty_valid = ($urandom_range(0, 3) == 0);
            duty_in = W'($urandom_range(0, 15));
            reset = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 1'b0;
        duty_valid = 1'b0;
        run(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
